audio_i2s_tx: RTL and testbench

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_bclk_div.sv | 33 +++
 rtl/audio_i2s_tx.sv | 83 ++++++++
 tb/tb_audio_i2s_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants: I2S frame geometry used by the transmitter and its helpers.
package audio_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int FRAME_BITS = 2 * SAMPLE_W;
   localparam int K_W        = $clog2(FRAME_BITS);

   // Bit-counter value at which a new frame is loaded (one-bit I2S delay after k=0).
   localparam logic [K_W-1:0] LOAD_K = K_W'(1);

   function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [SAMPLE_W-1:0] left,
                                                        input logic [SAMPLE_W-1:0] right);
      return {left, right};
   endfunction

endpackage

// File: rtl/audio_bclk_div.sv
// BCLK generator: toggles bclk every BCLK_DIV clks and flags the cycle whose edge drops bclk.
module audio_bclk_div #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic bclk,
   output logic fall_stb
);

   localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          at_end;

   assign at_end = (cnt == CW'(BCLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         bclk <= 1'b0;
      end else if (at_end) begin
         cnt  <= '0;
         bclk <= ~bclk;
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

   // High during the cycle whose closing edge takes bclk 1->0; consumers update on that edge.
   assign fall_stb = at_end & bclk;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one-pair holding register feeding a 32-bit MSB-first shift register.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int BCLK_DIV = 4,
   parameter int W        = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_left,
   input  logic [W-1:0] in_right,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         i2s_bclk,
   output logic         i2s_lrclk,
   output logic         i2s_sdata,
   output logic         underrun
);

   logic                  fall_stb;
   logic [K_W-1:0]        k;
   logic [K_W-1:0]        k_next;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] load_frame;
   logic [W-1:0]          hold_left;
   logic [W-1:0]          hold_right;
   logic                  hold_full;
   logic                  load;
   logic                  accept;

   audio_bclk_div #(.BCLK_DIV(BCLK_DIV)) u_bclk_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .bclk     (i2s_bclk),
      .fall_stb (fall_stb)
   );

   assign k_next     = k + K_W'(1);
   assign load       = fall_stb && (k_next == LOAD_K);
   assign in_ready   = ~hold_full;
   assign accept     = in_valid && in_ready;
   assign load_frame = hold_full ? pack_frame(hold_left, hold_right) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k         <= '1;
         i2s_lrclk <= 1'b1;
         i2s_sdata <= 1'b0;
         shreg     <= '0;
         underrun  <= 1'b0;
      end else begin
         underrun <= load && !hold_full;
         if (fall_stb) begin
            k         <= k_next;
            i2s_lrclk <= (k_next >= K_W'(SAMPLE_W));
            // On load the frame MSB goes straight to the pin; the rest queues behind it.
            if (load) begin
               i2s_sdata <= load_frame[FRAME_BITS-1];
               shreg     <= {load_frame[FRAME_BITS-2:0], 1'b0};
            end else begin
               i2s_sdata <= shreg[FRAME_BITS-1];
               shreg     <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
         end
      end
   end

   // A pair offered on an underrun load cycle lands in the freshly emptied register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full  <= 1'b0;
         hold_left  <= '0;
         hold_right <= '0;
      end else if (accept) begin
         hold_full  <= 1'b1;
         hold_left  <= in_left;
         hold_right <= in_right;
      end else if (load) begin
         hold_full  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx at BCLK_DIV=2 with a frame scoreboard on the serial output.
module tb_audio_i2s_tx;

   localparam int DIV = 2;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_left;
   logic [15:0] in_right;
   logic        in_valid;
   logic        in_ready;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic        underrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] exp_q[$];
   int          acc_q[$];

   int          bk = 31;
   logic        prev_bclk = 1'b0;
   logic [31:0] cur_exp = '0;
   bit          fall_flag = 1'b0;
   bit          in_rst = 1'b1;
   bit          first_pending = 1'b0;
   bit          exp_under;
   int          rel_cyc = 0;
   int          last_fall = 0;

   audio_i2s_tx #(.BCLK_DIV(DIV), .W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_left   (in_left),
      .in_right  (in_right),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .i2s_bclk  (i2s_bclk),
      .i2s_lrclk (i2s_lrclk),
      .i2s_sdata (i2s_sdata),
      .underrun  (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bclk"},     i2s_bclk,  1'b0);
      check({tag, "_lrclk"},    i2s_lrclk, 1'b1);
      check({tag, "_sdata"},    i2s_sdata, 1'b0);
      check({tag, "_underrun"}, underrun,  1'b0);
      check({tag, "_in_ready"}, in_ready,  1'b1);
   endtask

   // Monitor: tracks the bit counter, pops the expected frame at each load, checks every cycle.
   always @(negedge clk) begin
      fall_flag = 1'b0;
      if (!rst_n) begin
         check_reset_outputs("rst");
         bk        = 31;
         prev_bclk = 1'b0;
         cur_exp   = '0;
         exp_q.delete();
         acc_q.delete();
         in_rst    = 1'b1;
      end else begin
         if (in_rst) begin
            in_rst        = 1'b0;
            rel_cyc       = cyc;
            first_pending = 1'b1;
         end
         exp_under = 1'b0;
         if (prev_bclk && !i2s_bclk) begin
            fall_flag = 1'b1;
            if (first_pending) begin
               check("first_fall_delay", cyc - rel_cyc, 2 * DIV);
               first_pending = 1'b0;
            end else begin
               check("bclk_period", cyc - last_fall, 2 * DIV);
            end
            last_fall = cyc;
            bk = (bk + 1) % 32;
            if (bk == 1) begin
               if (exp_q.size() > 0 && acc_q[0] < cyc) begin
                  cur_exp = exp_q.pop_front();
                  void'(acc_q.pop_front());
               end else begin
                  cur_exp   = '0;
                  exp_under = 1'b1;
               end
            end
            check("lrclk", i2s_lrclk, (bk >= 16));
            check("sdata", i2s_sdata, cur_exp[31 - ((bk + 31) % 32)]);
         end
         check("underrun", underrun, exp_under);
         prev_bclk = i2s_bclk;
      end
   end

   task automatic send(input logic [15:0] l, input logic [15:0] r, input bit keep);
      bit done = 1'b0;
      in_left  = l;
      in_right = r;
      in_valid = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         if (in_ready) begin
            exp_q.push_back({l, r});
            acc_q.push_back(cyc + 1);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!keep) in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed not accepted expected accepted");
      end
   endtask

   task automatic wait_fall_k(input int kk);
      bit found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         #1;
         if (fall_flag && bk == kk) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $error("FAIL wait_k_timeout: observed no fall at k=%0d expected one", kk);
      end
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_left  = '0;
      in_right = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Pair accepted before the first frame load.
      send(16'hA5A5, 16'h0F0F, 1'b0);
      wait_fall_k(16);
      check("k16_lrclk", i2s_lrclk, 1'b1);
      check("k16_sdata_left_lsb", i2s_sdata, 1'b1);

      // Starvation: zero frames, one underrun pulse per 128 clks.
      wait_fall_k(1);
      n = 0;
      repeat (256) begin
         @(negedge clk);
         #1;
         if (underrun) n++;
      end
      check("underrun_count", n, 2);

      // Backpressure with valid held high across two pairs.
      send(16'h0001, 16'h8000, 1'b1);
      check("bp_ready_low", in_ready, 1'b0);
      send(16'h7FFF, 16'hFFFF, 1'b0);
      wait_fall_k(1);
      wait_fall_k(1);
      wait_fall_k(1);

      // Offer a pair exactly on an underrun frame-load edge.
      wait_fall_k(0);
      repeat (3) @(negedge clk);
      send(16'h1234, 16'hABCD, 1'b0);
      check("simul_underrun", underrun, 1'b1);
      check("simul_held", in_ready, 1'b0);
      wait_fall_k(1);
      wait_fall_k(1);

      // Reset mid-frame with a pair held.
      wait_fall_k(3);
      send(16'h5555, 16'h3333, 1'b0);
      check("mid_held", in_ready, 1'b0);
      wait_fall_k(20);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_fall_k(1);
      check("post_rst_underrun", underrun, 1'b1);
      wait_fall_k(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
